// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the request/priority arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   ARB_FIXED   : MODE value for fixed priority (index 3 highest)
//   ARB_RR      : MODE value for round-robin
//   N_REQ       : number of requesters
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int N_REQ     = 4;

endpackage

// File: rtl/arb_priority_pick.sv
// ---------------------------------------------------------------------------
// arb_priority_pick
// Combinational priority pick over 4 requests with a programmable start.
// The search begins at i_start and walks downward with wrap, so
// i_start = 3 gives plain fixed priority 3 > 2 > 1 > 0.
//   i_req    : request vector
//   i_start  : index searched first
//   o_found  : at least one request is set
//   o_winner : index of the selected request (valid when o_found = 1)
// ---------------------------------------------------------------------------
module arb_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_start,
  output logic             o_found,
  output logic [1:0]       o_winner
);

  logic [1:0] w_shift;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_pos;

  always_comb begin
    // Rotate so that i_start lands on bit 3: w_rot[k] = i_req[(k + w_shift) mod 4].
    w_shift = i_start + 2'd1;
    w_dbl   = {i_req, i_req} >> w_shift;
    w_rot   = w_dbl[3:0];

    o_found = 1'b1;
    w_pos   = 2'd0;
    case (w_rot) inside
      4'b1???: w_pos = 2'd3;
      4'b01??: w_pos = 2'd2;
      4'b001?: w_pos = 2'd1;
      4'b0001: w_pos = 2'd0;
      default: o_found = 1'b0;
    endcase

    // Undo the rotation; 2-bit addition wraps naturally.
    o_winner = w_pos + w_shift;
  end

endmodule

// File: rtl/req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// req_priority_arbiter
// Shares one downstream resource between 4 requesters. A registered one-hot
// grant is held until the owner releases it; every release is followed by
// one idle bubble cycle before re-arbitration.
//
// Protocol: a requester holds req[i] high while it wants the resource.
// Ownership starts in the cycle grant[i] is high and lasts until the owner
// pulses done, drops req[i], or the hold watchdog expires. No preemption.
//
// Parameters:
//   MODE     : ARB_FIXED (index 3 highest) or ARB_RR (round-robin)
//   MAX_HOLD : grant cycles before forced release, 0 disables the watchdog
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req         : level request per requester
//   done        : owner release pulse (ignored when idle)
//   grant       : registered one-hot grant
//   grant_id    : binary owner index (valid with grant_valid)
//   grant_valid : OR of grant
//   timeout     : one-cycle pulse on watchdog release
//   timeout_id  : owner that last timed out
// ---------------------------------------------------------------------------
module req_priority_arbiter
  import arb_pkg::*;
#(
  parameter int MODE     = ARB_FIXED,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout,
  output logic [1:0] timeout_id
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t       r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_grant_id;
  logic [1:0]       r_last_id;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic [1:0]       r_timeout_id;

  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_start;
  logic       w_release;
  logic       w_expire;

  // Round-robin searches below the last winner first; fixed mode always starts at 3.
  assign w_start = (MODE == ARB_RR) ? (r_last_id - 2'd1) : 2'd3;

  arb_priority_pick u_pick (
    .i_req    (req),
    .i_start  (w_start),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // r_cnt counts completed grant cycles minus one at the edge being evaluated,
  // so MAX_HOLD-1 marks the edge that ends the MAX_HOLD-th grant cycle.
  assign w_expire  = (MAX_HOLD > 0) && (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release = done || !req[r_grant_id];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= 4'b0000;
      r_grant_id   <= 2'd0;
      r_last_id    <= 2'd0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_timeout_id <= 2'd0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            r_grant    <= 4'b0001 << w_winner;
            r_grant_id <= w_winner;
            r_last_id  <= w_winner;
            r_cnt      <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            // Owner-driven release wins over a coincident watchdog expiry.
            r_state <= IDLE;
            r_grant <= 4'b0000;
          end else if (w_expire) begin
            r_state      <= IDLE;
            r_grant      <= 4'b0000;
            r_timeout    <= 1'b1;
            r_timeout_id <= r_grant_id;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 4'b0000;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = |r_grant;
  assign timeout     = r_timeout;
  assign timeout_id  = r_timeout_id;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_priority_arbiter
// Two arbiter instances: u_fix (fixed priority, MAX_HOLD = 8) and
// u_rr (round-robin, MAX_HOLD = 16). A cycle model predicts the outputs
// after every edge; predictions are queued and compared after the edge.
// Directed checks pin the scenarios down with hand-derived constants.
// ---------------------------------------------------------------------------
module tb_req_priority_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, rst_r;
  logic [3:0] req_f, req_r;
  logic       done_f, done_r;

  logic [3:0] grant_f, grant_r;
  logic [1:0] gid_f, gid_r;
  logic       gv_f, gv_r;
  logic       to_f, to_r;
  logic [1:0] tid_f, tid_r;

  req_priority_arbiter #(.MODE(0), .MAX_HOLD(8)) u_fix (
    .clk(clk), .rst_n(rst_f), .req(req_f), .done(done_f),
    .grant(grant_f), .grant_id(gid_f), .grant_valid(gv_f),
    .timeout(to_f), .timeout_id(tid_f)
  );

  req_priority_arbiter #(.MODE(1), .MAX_HOLD(16)) u_rr (
    .clk(clk), .rst_n(rst_r), .req(req_r), .done(done_r),
    .grant(grant_r), .grant_id(gid_r), .grant_valid(gv_r),
    .timeout(to_r), .timeout_id(tid_r)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // packed expectation: {grant[3:0], grant_id[1:0], valid, timeout, timeout_id[1:0]}
  logic [9:0] exp_q_f[$];
  logic [9:0] exp_q_r[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy[2];
  int m_gid[2];
  int m_held[2];
  int m_last[2];
  bit m_to[2];
  int m_tid[2];

  task automatic model_edge(input int u, input logic rst, input logic [3:0] rq,
                            input logic dn, input int mode, input int maxh);
    int first;
    int idx;
    bit hit;
    if (!rst) begin
      m_busy[u] = 0; m_gid[u] = 0; m_held[u] = 0;
      m_last[u] = 0; m_to[u] = 0; m_tid[u] = 0;
    end else begin
      m_to[u] = 0;
      if (!m_busy[u]) begin
        first = (mode == 1) ? (m_last[u] + 3) % 4 : 3;
        hit = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
          if (!hit && rq[(first - i + 4) % 4]) begin
            hit = 1;
            idx = (first - i + 4) % 4;
          end
        end
        if (hit) begin
          m_busy[u] = 1; m_gid[u] = idx; m_held[u] = 0; m_last[u] = idx;
        end
      end else begin
        m_held[u]++;
        if (dn || !rq[m_gid[u]]) begin
          m_busy[u] = 0;
        end else if (maxh > 0 && m_held[u] == maxh) begin
          m_busy[u] = 0; m_to[u] = 1; m_tid[u] = m_gid[u];
        end
      end
    end
  endtask

  function automatic logic [9:0] model_pack(input int u);
    logic [3:0] g;
    g = m_busy[u] ? (4'b0001 << m_gid[u]) : 4'b0000;
    return {g, 2'(m_gid[u]), m_busy[u], m_to[u], 2'(m_tid[u])};
  endfunction

  task automatic cmp_unit(input string nm, input logic [9:0] e, input logic [3:0] g,
                          input logic [1:0] gid, input logic gv, input logic to,
                          input logic [1:0] tid);
    check_eq({nm, "_grant"}, 32'(g), 32'(e[9:6]));
    check_eq({nm, "_valid"}, 32'(gv), 32'(e[3]));
    if (e[3]) check_eq({nm, "_grant_id"}, 32'(gid), 32'(e[5:4]));
    check_eq({nm, "_timeout"}, 32'(to), 32'(e[2]));
    check_eq({nm, "_timeout_id"}, 32'(tid), 32'(e[1:0]));
  endtask

  // ---------------- driver ----------------
  // Predict, advance one edge, then compare #1 after it.
  task automatic tick();
    logic [9:0] e;
    model_edge(0, rst_f, req_f, done_f, 0, 8);
    exp_q_f.push_back(model_pack(0));
    model_edge(1, rst_r, req_r, done_r, 1, 16);
    exp_q_r.push_back(model_pack(1));
    @(posedge clk);
    #1;
    if (exp_q_f.size() == 0 || exp_q_r.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q_f.pop_front();
      cmp_unit("fix", e, grant_f, gid_f, gv_f, to_f, tid_f);
      e = exp_q_r.pop_front();
      cmp_unit("rr", e, grant_r, gid_r, gv_r, to_r, tid_r);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_f = 1'b0; rst_r = 1'b0;
    req_f = 4'b0000; req_r = 4'b0000;
    done_f = 1'b0; done_r = 1'b0;
    #2;
    ticks(2);
    check_eq("rst_grant_f", 32'(grant_f), 32'h0);
    check_eq("rst_valid_r", 32'(gv_r), 32'h0);
    rst_f = 1'b1; rst_r = 1'b1;
    tick();

    // Fixed priority: 0110 -> owner 2
    req_f = 4'b0110;
    tick();
    check_eq("t1_grant", 32'(grant_f), 32'h4);
    check_eq("t1_id", 32'(gid_f), 32'd2);
    check_eq("t1_valid", 32'(gv_f), 32'd1);

    // No preemption by a higher request; done gives bubble then owner 3
    req_f = 4'b1100;
    ticks(2);
    check_eq("t2_hold", 32'(grant_f), 32'h4);
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    check_eq("t2_bubble", 32'(grant_f), 32'h0);
    tick();
    check_eq("t2_regrant", 32'(grant_f), 32'h8);
    req_f = 4'b0000;
    ticks(2);

    // Watchdog: 8 grant cycles, timeout pulse, re-grant after bubble
    req_f = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t4_held", 32'(gv_f), 32'd1);
    end
    tick();
    check_eq("t4_timeout", 32'(to_f), 32'd1);
    check_eq("t4_tid", 32'(tid_f), 32'd0);
    check_eq("t4_grant0", 32'(grant_f), 32'h0);
    tick();
    check_eq("t4_regrant", 32'(grant_f), 32'h1);
    check_eq("t4_pulse_end", 32'(to_f), 32'd0);
    req_f = 4'b0000;
    ticks(2);

    // Owner drops its request while a higher one waits
    req_f = 4'b0010;
    tick();
    check_eq("t5_grant1", 32'(grant_f), 32'h2);
    req_f = 4'b1010;
    tick();
    req_f = 4'b1000;
    tick();
    check_eq("t5_bubble", 32'(grant_f), 32'h0);
    check_eq("t5_no_to", 32'(to_f), 32'd0);
    tick();
    check_eq("t5_regrant", 32'(grant_f), 32'h8);
    req_f = 4'b0000;
    done_f = 1'b1;  // done in idle must be harmless
    ticks(3);
    done_f = 1'b0;
    check_eq("idle_done", 32'(gv_f), 32'd0);

    // Round-robin rotation 3,2,1,0,3
    req_r = 4'b1111;
    tick();
    check_eq("t3_first", 32'(gid_r), 32'd3);
    for (int k = 0; k < 4; k++) begin
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
      check_eq("t3_bubble", 32'(gv_r), 32'd0);
      tick();
      check_eq("t3_rot", 32'(gid_r), 32'((6 - k) % 4));
    end
    req_r = 4'b0000;
    ticks(2);

    // Reset mid-grant clears rotation state: first grant is 3, not 1
    req_r = 4'b0100;
    ticks(6);
    check_eq("t6_owner", 32'(grant_r), 32'h4);
    rst_r = 1'b0;
    req_r = 4'b1111;
    tick();
    check_eq("t6_rst_grant", 32'(grant_r), 32'h0);
    check_eq("t6_rst_to", 32'(to_r), 32'd0);
    rst_r = 1'b1;
    tick();
    check_eq("t6_first", 32'(gid_r), 32'd3);
    req_r = 4'b0000;
    ticks(2);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_f = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_r = 4'($urandom_range(0, 15));
      done_f = ($urandom_range(0, 9) == 0);
      done_r = ($urandom_range(0, 9) == 0);
      rst_f  = ($urandom_range(0, 99) != 0);
      rst_r  = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
